adc_sampler: RTL
================

# adc_sampler

Serial ADC front end for the thermistor path. It periodically runs an 8-bit SPI-style conversion read from an external ADC and holds the result on `sample[7:0]`. That bus drives the processor's discrete inputs `in0`..`in7`, with `sample[0]` going to `in0`. The block is the producing end of the digital-input interface that the processor consumes, and it replaces the constant `in*` stimulus at board level.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period. Legal range is ≥3, so the 2-flop MISO synchronizer settles inside the high phase.
- `SAMPLE_PERIOD`, default 1000: system clocks between conversion start opportunities. Must be ≥1.
- `clock`, in, 1: system clock. All state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run periodic conversions while high.
- `adc_miso`, in, 1: serial data from the ADC, asynchronous to `clock`, MSB first.
- `adc_cs_n`, out, 1: ADC chip select, active low, registered.
- `adc_sclk`, out, 1: SPI clock, mode 0 (idles low), registered.
- `sample`, out, 8: last completed conversion, held until the next one completes.
- `sample_valid`, out, 1: one-cycle pulse when `sample` updates.
- `busy`, out, 1: high whenever the FSM is not IDLE.
- `overrun`, out, 1: sticky flag, set when a start opportunity is missed because the FSM is busy.

## Operation
- **Reset values** (`reset_n`=0, effective immediately, including mid-conversion):
  - `adc_cs_n`=1, `adc_sclk`=0, `sample`=0, `sample_valid`=0, `busy`=0, `overrun`=0.
  - FSM=IDLE, period counter=0, bit counter=0, synchronizer flops=0.
- **Period counter:**
  - While `enable`=1, increments each clock and wraps from SAMPLE_PERIOD-1 to 0.
  - While `enable`=0, it is forced to 0.
  - A start opportunity is any edge with `enable`=1 and counter==0.
- **Start opportunity outcomes:**
  - FSM in IDLE: the conversion starts.
  - FSM in any other state: the opportunity is dropped and `overrun` is set.
- **Clearing `overrun`:** only by reset or by `enable`=0.
- **`adc_miso` sampling:** through a 2-flop synchronizer.
- **FSM states:**
  - IDLE: `cs_n`=1, `sclk`=0. On a start, go to SETUP and drive `cs_n`=0.
  - SETUP: `cs_n`=0, `sclk`=0 for CLK_DIV cycles, then go to HIGH with `sclk`=1.
  - HIGH: `sclk`=1 for CLK_DIV cycles. On the last cycle, shift the synchronized MISO into the shift register LSB (MSB-first, shift left). Then go to LOW with `sclk`=0.
  - LOW: `sclk`=0 for CLK_DIV cycles.
    - If fewer than 8 bits have been taken, go back to HIGH.
    - After the 8th bit, go to CSHIGH: drive `cs_n`=1, load `sample` from the shift register, and pulse `sample_valid`.
  - CSHIGH: `cs_n`=1 for CLK_DIV cycles (minimum deselect time), then go to IDLE.
- **Timing of a conversion:** `cs_n` is low for exactly 17·CLK_DIV cycles, covering 8 SCLK periods of 2·CLK_DIV. One conversion occupies the FSM for 18·CLK_DIV cycles.
- **Overrun threshold:** an overrun occurs whenever SAMPLE_PERIOD < 18·CLK_DIV + 1.
- **`enable` falling mid-conversion:** the conversion completes normally (no abort) and `sample_valid` still pulses. No new start occurs.
- **No partial update:** `sample` never changes except at the `sample_valid` cycle.

## Timing
- **Start latency:** if `enable` is first high at edge E, that edge is a start. `adc_cs_n` falls after E, and the first `sclk` rise occurs at E+CLK_DIV.
- **Output latency:** `sample`/`sample_valid` appear at E+17·CLK_DIV, the same cycle `adc_cs_n` returns high. `busy` deasserts at E+18·CLK_DIV.
- **Bit capture:** bit k (k=7..0) is captured at the edge ending its HIGH phase. That edge is E + CLK_DIV + (7-k)·2·CLK_DIV + CLK_DIV.
- **Requirement on the external ADC:** data must be stable from the `sclk` rise through the end of HIGH, which is ≥CLK_DIV-2 cycles after synchronization.
- **Start cadence:** consecutive starts are spaced exactly SAMPLE_PERIOD cycles apart while `enable` stays high.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.

## Test plan
- **Reset:** assert `reset_n`=0 mid-HIGH state → within the same cycle, `cs_n`=1, `sclk`=0, `sample`=0, `busy`=0. After release, `enable`=0 must produce no activity for 200 cycles.
- **Single conversion:** CLK_DIV=4, ADC model returns 0xA5, raise `enable` → `cs_n` low for 68 cycles and 8 `sclk` pulses of 4 high/4 low. `sample`=0xA5 with a single 1-cycle `sample_valid`, and `busy` high for 72 cycles.
- **Periodic updates:** SAMPLE_PERIOD=100, ADC returns 0x3C then 0xFF → `cs_n` falls exactly 100 cycles apart. `sample` reads 0x3C and then 0xFF, and `overrun`=0.
- **Overrun:** SAMPLE_PERIOD=50, CLK_DIV=4 → the opportunity at +50 is dropped and `overrun`=1; the next conversion starts at +100. Dropping `enable` clears `overrun`.
- **`enable` drop mid-conversion:** deassert `enable` after 3 `sclk` pulses, ADC returns 0x81 → the conversion finishes, `sample`=0x81 with `sample_valid`, and no further `cs_n` fall occurs.
- **MISO glitch tolerance:** toggle `adc_miso` during the LOW phases only, with a stable bit during HIGH (pattern 0x5A) → `sample`=0x5A.

Source files
------------

// File: rtl/adc_sampler.sv
// adc_sampler: periodic 8-bit SPI (mode 0) conversion reader for the
// thermistor ADC. Holds the last completed conversion on sample[7:0].
// All outputs come straight from flops; adc_miso passes a 2-flop synchronizer.
module adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PER_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PER_ONE  = PW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_CSHIGH = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [PW-1:0]   period_q, period_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic [7:0]      sample_q, sample_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic            div_last_s;
  logic            opp_s;
  logic            start_s;
  logic            miss_s;

  // A start opportunity is any enabled edge with the period counter at zero;
  // it only launches a conversion when the FSM is idle, otherwise it is lost.
  assign div_last_s = (div_q == DIV_LAST);
  assign opp_s      = enable && (period_q == PER_ZERO);
  assign start_s    = opp_s && (state_q == ST_IDLE);
  assign miss_s     = opp_s && (state_q != ST_IDLE);

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      div_q     <= DIV_ZERO;
      bit_q     <= 4'd0;
      period_q  <= PER_ZERO;
      shift_q   <= 8'h00;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sample_q  <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      period_q  <= period_d;
      shift_q   <= shift_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Free-running period counter, held at zero while disabled.
  always_comb begin
    period_d = PER_ZERO;
    if (!enable) begin
      period_d = PER_ZERO;
    end else if (period_q == PER_LAST) begin
      period_d = PER_ZERO;
    end else begin
      period_d = period_q + PER_ONE;
    end
  end

  // Next-state logic: each non-idle state lasts CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_SETUP;
          div_d   = DIV_ZERO;
          bit_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_last_s) begin
          state_d = ST_HIGH;
          div_d   = DIV_ZERO;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_HIGH: begin
        if (div_last_s) begin
          state_d = ST_LOW;
          div_d   = DIV_ZERO;
          bit_d   = bit_q + 4'd1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_LOW: begin
        if (div_last_s) begin
          div_d = DIV_ZERO;
          if (bit_q == 4'd8) begin
            state_d = ST_CSHIGH;
          end else begin
            state_d = ST_HIGH;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_CSHIGH: begin
        if (div_last_s) begin
          state_d = ST_IDLE;
          div_d   = DIV_ZERO;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = DIV_ZERO;
        bit_d   = 4'd0;
      end
    endcase
  end

  // Output logic: pin levels follow the next state so they leave the flops
  // aligned with the state register; data capture happens at end of HIGH.
  always_comb begin
    cs_n_d    = 1'b1;
    sclk_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    sync1_d   = adc_miso;
    sync2_d   = sync1_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    case (state_d)
      ST_IDLE:   begin cs_n_d = 1'b1; sclk_d = 1'b0; end
      ST_SETUP:  begin cs_n_d = 1'b0; sclk_d = 1'b0; end
      ST_HIGH:   begin cs_n_d = 1'b0; sclk_d = 1'b1; end
      ST_LOW:    begin cs_n_d = 1'b0; sclk_d = 1'b0; end
      ST_CSHIGH: begin cs_n_d = 1'b1; sclk_d = 1'b0; end
      default:   begin cs_n_d = 1'b1; sclk_d = 1'b0; end
    endcase
    if ((state_q == ST_HIGH) && div_last_s) begin
      shift_d = {shift_q[6:0], sync2_q};
    end else begin
      shift_d = shift_q;
    end
    if ((state_q == ST_LOW) && (state_d == ST_CSHIGH)) begin
      sample_d = shift_q;
      valid_d  = 1'b1;
    end else begin
      sample_d = sample_q;
      valid_d  = 1'b0;
    end
    if (!enable) begin
      overrun_d = 1'b0;
    end else if (miss_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
